// File: rtl/dct_odd_serial_mac.sv
// Serial odd-coefficient DCT engine: one shift-add product per cycle, then
// round, saturate and hand off each coefficient y(2k+1) over a valid/ready port.
module dct_odd_serial_mac #(
    parameter int WIDTH = 19,
    parameter int SHIFT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_size,
    input  logic [16*WIDTH-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [4:0]              out_index,
    output logic                    out_last
);

    localparam int ACC_W = WIDTH + 11;
    localparam int CW    = 7;

    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'((64'd1 << SHIFT) >> 1);
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

    state_t                  state_reg;
    logic [1:0]              size_reg;
    logic [3:0]              k_reg;
    logic [3:0]              j_reg;
    logic [6:0]              p_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [WIDTH-1:0] data_reg [16];
    logic                    out_valid_reg;
    logic signed [WIDTH-1:0] out_data_reg;
    logic [4:0]              out_index_reg;
    logic                    out_last_reg;

    logic [3:0]              m_last;
    logic [6:0]              p_mask;
    logic [6:0]              p_step;
    logic [6:0]              p_next;
    logic [7:0]              n_val;
    logic [7:0]              p_ext;
    logic [7:0]              diff;
    logic                    coef_neg;
    logic [3:0]              coef_idx;
    logic [CW-1:0]           coef_mag;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] pp [CW];
    logic signed [ACC_W-1:0] prod_mag;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W:0]   rounded;
    logic signed [WIDTH-1:0] sat_value;

    always_comb begin
        case (size_reg)
            2'd0:    begin m_last = 4'd3;  p_mask = 7'd31;  end
            2'd1:    begin m_last = 4'd7;  p_mask = 7'd63;  end
            default: begin m_last = 4'd15; p_mask = 7'd127; end
        endcase
    end

    // p = (2j+1)(2k+1) mod 4N is tracked incrementally: each step in j adds 2(2k+1).
    assign p_step = {1'b0, k_reg, 1'b1, 1'b0};
    assign p_next = (p_reg + p_step) & p_mask;

    always_comb begin
        n_val    = 8'd8 << size_reg;
        p_ext    = {1'b0, p_reg};
        coef_neg = 1'b0;
        if (p_ext < n_val) begin
            diff = p_ext - 8'd1;
        end else if (p_ext < (n_val << 1)) begin
            diff     = (n_val << 1) - p_ext - 8'd1;
            coef_neg = 1'b1;
        end else if (p_ext < ((n_val << 1) + n_val)) begin
            diff     = p_ext - (n_val << 1) - 8'd1;
            coef_neg = 1'b1;
        end else begin
            diff = (n_val << 2) - p_ext - 8'd1;
        end
        coef_idx = diff[4:1];
    end

    always_comb begin
        coef_mag = '0;
        case (size_reg)
            2'd0: begin
                case (coef_idx[1:0])
                    2'd0:    coef_mag = 7'd89;
                    2'd1:    coef_mag = 7'd75;
                    2'd2:    coef_mag = 7'd50;
                    default: coef_mag = 7'd18;
                endcase
            end
            2'd1: begin
                case (coef_idx[2:0])
                    3'd0:    coef_mag = 7'd90;
                    3'd1:    coef_mag = 7'd87;
                    3'd2:    coef_mag = 7'd80;
                    3'd3:    coef_mag = 7'd70;
                    3'd4:    coef_mag = 7'd57;
                    3'd5:    coef_mag = 7'd43;
                    3'd6:    coef_mag = 7'd25;
                    default: coef_mag = 7'd9;
                endcase
            end
            default: begin
                case (coef_idx)
                    4'd0:    coef_mag = 7'd90;
                    4'd1:    coef_mag = 7'd90;
                    4'd2:    coef_mag = 7'd88;
                    4'd3:    coef_mag = 7'd85;
                    4'd4:    coef_mag = 7'd82;
                    4'd5:    coef_mag = 7'd78;
                    4'd6:    coef_mag = 7'd73;
                    4'd7:    coef_mag = 7'd67;
                    4'd8:    coef_mag = 7'd61;
                    4'd9:    coef_mag = 7'd54;
                    4'd10:   coef_mag = 7'd46;
                    4'd11:   coef_mag = 7'd38;
                    4'd12:   coef_mag = 7'd31;
                    4'd13:   coef_mag = 7'd22;
                    4'd14:   coef_mag = 7'd13;
                    default: coef_mag = 7'd4;
                endcase
            end
        endcase
    end

    // Shift-add product: one shifted copy of the sample per set coefficient bit.
    assign sample_ext = ACC_W'(data_reg[j_reg]);

    generate
        for (genvar gi = 0; gi < CW; gi++) begin : g_pp
            assign pp[gi] = coef_mag[gi] ? (sample_ext <<< gi) : '0;
        end
    endgenerate

    always_comb begin
        prod_mag = '0;
        for (int i = 0; i < CW; i++) begin
            prod_mag = prod_mag + pp[i];
        end
        prod = coef_neg ? -prod_mag : prod_mag;
    end

    always_comb begin
        rounded = ($signed({acc_reg[ACC_W-1], acc_reg}) + RND) >>> SHIFT;
        if (rounded > MAXV) begin
            sat_value = MAXV[WIDTH-1:0];
        end else if (rounded < MINV) begin
            sat_value = MINV[WIDTH-1:0];
        end else begin
            sat_value = rounded[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && in_valid && !rst) begin
            for (int i = 0; i < 16; i++) begin
                data_reg[i] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            size_reg      <= 2'd0;
            k_reg         <= 4'd0;
            j_reg         <= 4'd0;
            p_reg         <= 7'd0;
            acc_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_index_reg <= 5'd0;
            out_last_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        size_reg  <= (in_size == 2'd3) ? 2'd2 : in_size;
                        k_reg     <= 4'd0;
                        j_reg     <= 4'd0;
                        p_reg     <= 7'd1;
                        acc_reg   <= '0;
                        state_reg <= MAC;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + prod;
                    j_reg   <= j_reg + 4'd1;
                    p_reg   <= p_next;
                    if (j_reg == m_last) begin
                        state_reg <= OUT;
                    end
                end
                OUT: begin
                    // First OUT cycle registers the result; it then holds until accepted.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= sat_value;
                        out_index_reg <= {1'b0, k_reg};
                        out_last_reg  <= (k_reg == m_last);
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (k_reg == m_last) begin
                            state_reg <= IDLE;
                        end else begin
                            k_reg     <= k_reg + 4'd1;
                            j_reg     <= 4'd0;
                            p_reg     <= {1'b0, k_reg + 4'd1, 1'b1};
                            acc_reg   <= '0;
                            state_reg <= MAC;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_index = out_index_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_dct_odd_serial_mac.sv
// Bench for dct_odd_serial_mac: two instances (SHIFT=0 and SHIFT=7) run in lockstep
// against an arithmetic model of the odd DCT coefficients.
module tb_dct_odd_serial_mac;

    localparam int WIDTH = 19;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [1:0]              in_size;
    logic [16*WIDTH-1:0]     in_data;
    logic                    out_ready;

    logic                    ir0, ov0, ol0, ir7, ov7, ol7;
    logic signed [WIDTH-1:0] od0, od7;
    logic [4:0]              oi0, oi7;

    int total = 0;
    int bad   = 0;
    int vec [16];

    always #5 clk = ~clk;

    dct_odd_serial_mac #(.WIDTH(WIDTH), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_size(in_size),
        .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_index(oi0), .out_last(ol0)
    );

    dct_odd_serial_mac #(.WIDTH(WIDTH), .SHIFT(7)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir7), .in_size(in_size),
        .in_data(in_data), .out_valid(ov7), .out_ready(out_ready), .out_data(od7),
        .out_index(oi7), .out_last(ol7)
    );

    function automatic int tval(input int n, input int i);
        int t32 [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
        int t16 [8]  = '{90, 87, 80, 70, 57, 43, 25, 9};
        int t8  [4]  = '{89, 75, 50, 18};
        if (n == 8) return t8[i];
        if (n == 16) return t16[i];
        return t32[i];
    endfunction

    function automatic int model_y(input int size, input int k, input int shift);
        int     n, p, c;
        longint acc, r, maxv, minv;
        n   = (size == 0) ? 8 : (size == 1) ? 16 : 32;
        acc = 0;
        for (int j = 0; j < n / 2; j++) begin
            p = ((2 * j + 1) * (2 * k + 1)) % (4 * n);
            if (p < n)          c = tval(n, (p - 1) / 2);
            else if (p < 2 * n) c = -tval(n, (2 * n - p - 1) / 2);
            else if (p < 3 * n) c = -tval(n, (p - 2 * n - 1) / 2);
            else                c = tval(n, (4 * n - p - 1) / 2);
            acc += longint'(c) * longint'(vec[j]);
        end
        if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        else           r = acc;
        maxv = (64'sd1 <<< (WIDTH - 1)) - 1;
        minv = -(64'sd1 <<< (WIDTH - 1));
        if (r > maxv) r = maxv;
        if (r < minv) r = minv;
        return int'(r);
    endfunction

    function automatic int rand_sample();
        int r;
        r = int'($urandom);
        return r >>> (32 - WIDTH);
    endfunction

    // mode 0: always ready (latency checked), 1: 10-cycle stall per output, 2: random ready
    task automatic run_vec(input int size, input int mode);
        int  m, k, since, stall_cnt, guard, e0, e7;
        bit  seen, hs_pending;
        logic signed [WIDTH-1:0] held0;
        logic [4:0] heldi;
        m = (size == 0) ? 4 : (size == 1) ? 8 : 16;
        guard = 0;
        @(negedge clk);
        while (!ir0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (ir0 !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", ir0);
            return;
        end
        in_size = 2'(size);
        for (int j = 0; j < 16; j++) in_data[j*WIDTH +: WIDTH] = vec[j][WIDTH-1:0];
        in_valid  = 1'b1;
        out_ready = (mode == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_size  = 2'($urandom);
        for (int j = 0; j < 16; j++) in_data[j*WIDTH +: WIDTH] = WIDTH'($urandom);
        total++;
        if (ir0 !== 1'b0 || ir7 !== 1'b0) begin
            bad++;
            $display("FAIL in_ready_busy: in_ready=%b/%b required 0", ir0, ir7);
        end
        k = 0; since = 0; seen = 0; hs_pending = 0; stall_cnt = 0; guard = 0;
        while (k < m && guard < 5000) begin
            @(posedge clk);
            guard++;
            if (hs_pending) begin
                k++;
                since = 0;
                seen = 0;
                hs_pending = 0;
            end else begin
                since++;
            end
            @(negedge clk);
            if (k >= m) break;
            if (ov0) begin
                if (!seen) begin
                    seen = 1;
                    stall_cnt = 0;
                    e0 = model_y(size, k, 0);
                    e7 = model_y(size, k, 7);
                    total++;
                    if ($signed(od0) !== e0) begin
                        bad++;
                        $display("FAIL data_shift0 size=%0d k=%0d: got %0d required %0d", size, k, od0, e0);
                    end
                    total++;
                    if (ov7 !== 1'b1 || $signed(od7) !== e7) begin
                        bad++;
                        $display("FAIL data_shift7 size=%0d k=%0d: got %0d (valid %b) required %0d", size, k, od7, ov7, e7);
                    end
                    total++;
                    if (oi0 !== 5'(k) || oi7 !== 5'(k)) begin
                        bad++;
                        $display("FAIL index: got %0d/%0d required %0d", oi0, oi7, k);
                    end
                    total++;
                    if (ol0 !== (k == m - 1) || ol7 !== (k == m - 1)) begin
                        bad++;
                        $display("FAIL last k=%0d: got %b/%b required %b", k, ol0, ol7, (k == m - 1));
                    end
                    if (mode == 0) begin
                        total++;
                        if (since != m + 1) begin
                            bad++;
                            $display("FAIL latency k=%0d: valid after %0d edges required %0d", k, since, m + 1);
                        end
                    end
                    $display("out size=%0d k=%0d y0=%0d y7=%0d", size, k, od0, od7);
                    held0 = od0;
                    heldi = oi0;
                end else begin
                    total++;
                    if (od0 !== held0 || oi0 !== heldi) begin
                        bad++;
                        $display("FAIL hold: data=%0d idx=%0d required data=%0d idx=%0d", od0, oi0, held0, heldi);
                    end
                end
                if (mode == 1) begin
                    stall_cnt++;
                    out_ready = (stall_cnt > 10);
                    if (!out_ready) begin
                        total++;
                        if (ir0 !== 1'b0) begin
                            bad++;
                            $display("FAIL stall_in_ready: got %b required 0", ir0);
                        end
                    end
                end else if (mode == 2) begin
                    out_ready = 1'($urandom);
                end else begin
                    out_ready = 1'b1;
                end
                hs_pending = out_ready;
            end else if (seen) begin
                total++;
                bad++;
                $display("FAIL valid_dropped k=%0d: out_valid=0 required 1", k);
                seen = 0;
            end
        end
        total++;
        if (k < m) begin
            bad++;
            $display("FAIL timeout: received %0d outputs required %0d", k, m);
        end
        total++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
            bad++;
            $display("FAIL idle_after: in_ready=%b out_valid=%b required 1/0", ir0, ov0);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_size = 2'd0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (ov0 !== 1'b0 || od0 !== '0 || oi0 !== 5'd0 || ol0 !== 1'b0 ||
            ov7 !== 1'b0 || od7 !== '0 || oi7 !== 5'd0 || ol7 !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: v=%b d=%0d i=%0d l=%b required all 0", ov0, od0, oi0, ol0);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (ir0 !== 1'b1 || ir7 !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b/%b required 1", ir0, ir7);
        end
        $display("reset checked");
    endtask

    task automatic test_impulse();
        for (int j = 0; j < 16; j++) vec[j] = 0;
        vec[0] = 1;
        run_vec(0, 0);
    endtask

    task automatic test_sign_fold();
        for (int j = 0; j < 16; j++) vec[j] = 1;
        run_vec(2, 0);
        for (int j = 0; j < 16; j++) vec[j] = 0;
        vec[5] = 1;
        run_vec(2, 2);
    endtask

    task automatic test_saturation();
        for (int j = 0; j < 16; j++) vec[j] = 262143;
        run_vec(2, 0);
        for (int j = 0; j < 16; j++) vec[j] = -262144;
        run_vec(3, 2);
    endtask

    task automatic test_backpressure();
        for (int j = 0; j < 16; j++) vec[j] = rand_sample();
        run_vec(1, 1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 16; j++) begin
                if (t % 2 == 0) vec[j] = rand_sample();
                else            vec[j] = int'($urandom_range(0, 400)) - 200;
            end
            run_vec(int'($urandom_range(0, 3)), (t % 3 == 0) ? 0 : 2);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        bit spurious;
        for (int j = 0; j < 16; j++) vec[j] = rand_sample();
        @(negedge clk);
        in_size = 2'd2;
        for (int j = 0; j < 16; j++) in_data[j*WIDTH +: WIDTH] = vec[j][WIDTH-1:0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!(ov0 === 1'b1 && oi0 === 5'd4) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!(ov0 === 1'b1 && oi0 === 5'd4)) begin
            bad++;
            $display("FAIL reset_mid_reach: index=%0d valid=%b required 4/1", oi0, ov0);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (ov0 !== 1'b0 || od0 !== '0 || oi0 !== 5'd0 || ol0 !== 1'b0 || ir0 !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: v=%b d=%0d i=%0d l=%b rdy=%b required 0/0/0/0/1", ov0, od0, oi0, ol0, ir0);
        end
        rst = 1'b0;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov0 !== 1'b0 || ov7 !== 1'b0) spurious = 1;
        end
        total++;
        if (spurious) begin
            bad++;
            $display("FAIL reset_abandon: out_valid seen after reset required none");
        end
        $display("reset mid-vector checked");
        for (int j = 0; j < 16; j++) vec[j] = rand_sample();
        run_vec(2, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_impulse();
        test_sign_fold();
        test_saturation();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_odd_serial_mac.md
DCT_ODD_SERIAL_MAC -- requirements
Module: dct_odd_serial_mac

Interface
REQ-001 The block SHALL have parameter WIDTH, 19, signed bit width of each input sample and of the output.
REQ-002 The block SHALL have parameter SHIFT, 0, arithmetic right-shift applied to each accumulated result before output (0..12).
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-005 The block SHALL have port in_valid, input, 1, input vector valid.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a vector.
REQ-007 The block SHALL have port in_size, input, 2, transform size: 0=8-pt, 1=16-pt, 2=32-pt, 3 treated as 32-pt.
REQ-008 The block SHALL have port in_data, input, 16*WIDTH, signed samples b0..b15 with b[j] at bits [j*WIDTH +: WIDTH]; only b0..b(M-1) are used, M = N/2.
REQ-009 The block SHALL have port out_valid, output, 1, odd coefficient valid.
REQ-010 The block SHALL have port out_ready, input, 1, downstream accepts output.
REQ-011 The block SHALL have port out_data, output, WIDTH, signed odd DCT coefficient y(2k+1).
REQ-012 The block SHALL have port out_index, output, 5, index k of the current output (0..M-1).
REQ-013 The block SHALL have port out_last, output, 1, high with out_valid when k = M-1.

Function
REQ-014 The block SHALL compute y(2k+1) = sum over j=0..M-1 of c(k,j)*b[j], for k = 0..M-1 in ascending order.
REQ-015 Coefficients SHALL be derived as follows, with p = ((2j+1)(2k+1)) mod 4N: p<N gives +T[(p-1)/2]; p<2N gives -T[(2N-p-1)/2]; p<3N gives -T[(p-2N-1)/2]; otherwise +T[(4N-p-1)/2].
REQ-016 The coefficient tables SHALL be: T32 = 90,90,88,85,82,78,73,67,61,54,46,38,31,22,13,4; T16 = 90,87,80,70,57,43,25,9; T8 = 89,75,50,18.
REQ-017 Products SHALL be formed multiplier-free, using shift-add on constant coefficient bits, at one product per cycle through a single shared datapath.
REQ-018 The accumulator SHALL be WIDTH+11 bits signed and SHALL NOT overflow internally.
REQ-019 Output SHALL be (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 FSM states SHALL be IDLE, MAC, OUT.
- IDLE: in_ready=1; the handshake edge captures in_data and in_size, sets k=0, j=0, acc=0, and moves to MAC.
- MAC: one product per edge, j=0..M-1; at j=M-1 moves to OUT.
- OUT: the round/saturate result is registered at entry; out_valid=1.
REQ-021 In OUT, out_data, out_index and out_last SHALL be held stable while out_ready=0.
REQ-022 The output handshake edge in OUT SHALL go to IDLE if k=M-1; otherwise it SHALL set k=k+1, j=0, acc=0 and go to MAC.
REQ-023 For a vector accepted at edge 0, out_valid SHALL be high after edge M+1, and each later output SHALL be valid M+1 edges after the previous output handshake.
REQ-024 in_ready SHALL be 0 outside IDLE, and in_valid SHALL be ignored while in_ready=0.
REQ-025 Changes on in_data or in_size after capture SHALL NOT affect an in-progress vector.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL return to IDLE and clear out_valid, out_data, out_index, out_last and the accumulator to 0.
REQ-027 in_ready SHALL be 1 after the first edge with rst=0.
REQ-028 A reset mid-vector SHALL abandon the vector with no further out_valid.

Verification
REQ-029 Impulse test: size=0, SHIFT=0, b0=1, others 0 -> outputs 89,75,50,18; out_index 0..3; out_last only on the 4th output.
REQ-030 Sign folding: size=2, SHIFT=0, b0..b15=1 -> y1=922; size=2, only b5=1 -> y3=-4.
REQ-031 Saturation: WIDTH=19, size=2, all b=262143 -> y1=262143; all b=-262144 -> y1=-262144.
REQ-032 Rounding: SHIFT=7, size=0, b0=1 -> outputs 1,1,0,0.
REQ-033 Back-pressure: out_ready=0 for 10 cycles in OUT -> out_data/out_index stable, in_ready=0, no lost or duplicated outputs; with out_ready=1, the first output is valid after edge M+1 and outputs are spaced M+2 cycles apart.
REQ-034 Reset mid-MAC at size=2, k=5 -> all outputs 0 next cycle, in_ready=1, and a new vector gives correct results.
